pico_input_sequencer: RTL
=========================

# pico_input_sequencer

Upstream input stage for the picoMIPS Gaussian core. Synchronises and debounces the board switches and a push-button. On each accepted press, it presents one 8-bit switch sample on `SW` and a `branch_status` low pulse, which is the handshake the picoMIPS program polls before it reads a new operand. It sits between the board pins and the `SW`/`branch_status` inputs of the processor top level, in the `fastclk` domain.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required to accept a key press or release (boards override to ~500000).
- `PULSE_CYCLES`, 8: number of cycles `branch_status` is held low per accepted sample; must be ≥1.
- `fastclk  in  1`: the single system clock; all state is clocked on the rising edge.
- `reset  in  1`: reset is asynchronous and active-low, asserted by driving `reset` low.
- `sw_raw  in  8`: asynchronous board switches.
- `key_raw  in  1`: asynchronous push-button, active-low (0 = pressed).
- `SW  out  8`: latched sample to the processor.
- `branch_status  out  1`: handshake to the processor. Idles high; driven low for `PULSE_CYCLES` per sample.
- `busy  out  1`: high in every state except IDLE.
- `sample_count  out  8`: present only with `SAMPLE_COUNT_EN` (see Configuration).

## Operation
- Synchroniser: two-flop synchronisers on `sw_raw` and `key_raw`. Only the synchronised values, `sw_s` and `key_s`, are used downstream.
- Debounce counter: width `$clog2(DEBOUNCE_CYCLES+1)`.
  - Counts while `key_s` holds the level the current state is waiting for.
  - Clears to 0 on any change of `key_s`.
  - Saturates at `DEBOUNCE_CYCLES`.
- FSM states: IDLE, PRESS_DB, PRESENT, RELEASE_DB.
- IDLE → PRESS_DB when `key_s == 0`.
- PRESS_DB:
  - If `key_s` returns to 1 before the count reaches `DEBOUNCE_CYCLES`, go back to IDLE; the counter clears.
  - When the count reaches `DEBOUNCE_CYCLES`, latch `SW <= sw_s`, clear the pulse counter and go to PRESENT.
- PRESENT:
  - `branch_status = 0`.
  - The pulse counter increments every cycle.
  - After `PULSE_CYCLES` cycles, go to RELEASE_DB.
  - `key_s` and `sw_s` are ignored in this state.
- RELEASE_DB:
  - Requires `key_s == 1` for `DEBOUNCE_CYCLES` consecutive cycles, then go to IDLE.
  - Any 0 on `key_s` restarts the count.
  - A held key never produces a second sample.
- `SW` changes only on the PRESS_DB → PRESENT transition. Between samples it holds its value, whatever `sw_raw` does.

## Timing
- Reset values:
  - `SW = 8'h00`.
  - `branch_status = 1`.
  - `busy = 0`.
  - `sample_count = 0`.
  - FSM in IDLE.
  - All counters and synchroniser flops at 0, except the key synchroniser, which resets to 1 (released).
- Press-to-sample latency: a clean press changes `key_raw` at cycle 0.
  - `key_s` falls at cycle 2.
  - FSM is in PRESS_DB at cycle 3.
  - `SW` updates and `branch_status` falls at cycle 3 + `DEBOUNCE_CYCLES`, registered.
- `branch_status` low width is exactly `PULSE_CYCLES` cycles. `SW` is stable for the whole low period and afterwards.
- All outputs are registered; there are no combinational paths from input to output.
- Reset mid-operation: asynchronous return to the reset values, including during PRESENT. Any partial pulse is truncated and `branch_status` goes high immediately.
- `sw_raw` changing in the same cycle as the debounce completes: the sampled value is the `sw_s` present on that clock edge.

## Configuration
- `PICO_SAMPLE_COUNT_EN` defined:
  - Adds the `sample_count` output port.
  - Increments on each PRESS_DB → PRESENT transition.
  - Wraps 255 → 0.
- `PICO_SAMPLE_COUNT_EN` undefined: the port and its register do not exist; all other behaviour is identical.

## Structure
- Shared package `pico_pkg`:
  - FSM state typedef `seq_state_t` (IDLE, PRESS_DB, PRESENT, RELEASE_DB).
  - `DATA_W = 8`, used for the widths of `SW`, `sw_raw` and `sample_count`.
- Sub-module `pico_debounce`:
  - Synchroniser plus counter for one bit.
  - Outputs `stable_level` and a one-cycle `stable_evt`.
  - Instantiated once for the key.
  - The switches use plain two-flop synchronisers, not debouncing.

## Test plan
- Reset behaviour: hold `reset` low for 10 cycles with `key_raw = 0`.
  - Required during reset: `SW = 0x00`, `branch_status = 1`, `busy = 0`.
  - Release `reset`; with the key still pressed, one sample must follow after 3 + 16 cycles.
- Clean press: `sw_raw = 0x58`, then press the key and hold it for 40 cycles.
  - Required: `SW = 0x58` and `branch_status` low for exactly 8 cycles, starting 19 cycles after the press.
  - Exactly one pulse while the key is held.
- Bounce rejection: toggle `key_raw` every 5 cycles for 60 cycles (`DEBOUNCE_CYCLES = 16`), then release.
  - Required: no pulse, and `SW` keeps its previous value.
- Second sample: after the first sample, release for 30 cycles, set `sw_raw = 0x80`, then press again.
  - Required: `SW = 0x80` and a second 8-cycle low pulse.
  - `sample_count = 2` with `PICO_SAMPLE_COUNT_EN`.
- Reset mid-pulse: assert `reset` 3 cycles into PRESENT.
  - Required: `branch_status = 1` and `SW = 0x00` immediately, without waiting for a clock edge.
- Counter wrap, with `PICO_SAMPLE_COUNT_EN`: apply 256 clean press/release cycles.
  - Required: `sample_count` reads 0 after the 256th sample.

Source files
------------

// File: rtl/pico_pkg.sv
// Shared types and widths for the picoMIPS input sequencer.
package pico_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        PRESENT    = 2'd2,
        RELEASE_DB = 2'd3
    } seq_state_t;

endpackage

// File: rtl/pico_debounce.sv
// Two-flop synchroniser plus debounce counter for one asynchronous bit.
// stable_level flips after the synchronised input has differed from it for DEBOUNCE_CYCLES cycles.
module pico_debounce #(
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RESET_LEVEL     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic sync_level,
    output logic stable_level,
    output logic stable_evt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             meta_q;
    logic             sync_q;
    logic             level_q, level_d;
    logic             evt_q, evt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count cycles the synchronised input disagrees with the accepted level; any agreement restarts it.
    always_comb begin
        level_d = level_q;
        evt_d   = 1'b0;
        cnt_d   = cnt_q;
        if (sync_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_MAX) begin
                level_d = sync_q;
                evt_d   = 1'b1;
            end else begin
                level_d = level_q;
            end
        end
    end

    // Synchroniser and debounce state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= RESET_LEVEL;
            sync_q  <= RESET_LEVEL;
            level_q <= RESET_LEVEL;
            evt_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= raw;
            sync_q  <= meta_q;
            level_q <= level_d;
            evt_q   <= evt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sync_level   = sync_q;
    assign stable_level = level_q;
    assign stable_evt   = evt_q;

endmodule

// File: rtl/pico_input_sequencer.sv
// Switch/push-button front end for picoMIPS: one SW sample and a branch_status low pulse per press.
// Optional feature: define PICO_SAMPLE_COUNT_EN to add the sample_count output.
module pico_input_sequencer
    import pico_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PULSE_CYCLES    = 8
) (
    input  logic              fastclk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sw_raw,
    input  logic              key_raw,
    output logic [DATA_W-1:0] SW,
    output logic              branch_status,
    output logic              busy
`ifdef PICO_SAMPLE_COUNT_EN
    ,
    output logic [DATA_W-1:0] sample_count
`endif
);

    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);

    logic              key_s;
    logic              key_stable;
    logic              key_evt;
    logic [DATA_W-1:0] sw_meta_q;
    logic [DATA_W-1:0] sw_s;
    seq_state_t        state_q, state_d;
    logic [PW-1:0]     pulse_q, pulse_d;
    logic [DATA_W-1:0] sw_out_q, sw_out_d;
    logic              bs_q, bs_d;
    logic              busy_q, busy_d;
    logic              load_s;

    pico_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_LEVEL    (1'b1)
    ) u_key_db (
        .clk         (fastclk),
        .rst_n       (reset),
        .raw         (key_raw),
        .sync_level  (key_s),
        .stable_level(key_stable),
        .stable_evt  (key_evt)
    );

    // Switch synchroniser; the switches are sampled, not debounced.
    always_ff @(posedge fastclk or negedge reset) begin
        if (!reset) begin
            sw_meta_q <= '0;
            sw_s      <= '0;
        end else begin
            sw_meta_q <= sw_raw;
            sw_s      <= sw_meta_q;
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d  = state_q;
        pulse_d  = pulse_q;
        sw_out_d = sw_out_q;
        load_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!key_s) state_d = PRESS_DB;
                else        state_d = IDLE;
            end
            PRESS_DB: begin
                if (key_s) begin
                    state_d = IDLE;
                end else if (key_evt && !key_stable) begin
                    state_d  = PRESENT;
                    sw_out_d = sw_s;
                    pulse_d  = '0;
                    load_s   = 1'b1;
                end else begin
                    state_d = PRESS_DB;
                end
            end
            PRESENT: begin
                pulse_d = pulse_q + PW'(1);
                if (pulse_q == PULSE_LAST) state_d = RELEASE_DB;
                else                       state_d = PRESENT;
            end
            RELEASE_DB: begin
                // Level, not event: a release that settled during PRESENT still counts.
                if (key_stable) state_d = IDLE;
                else            state_d = RELEASE_DB;
            end
            default: state_d = IDLE;
        endcase
        bs_d   = (state_d != PRESENT);
        busy_d = (state_d != IDLE);
    end

    // FSM state and output registers.
    always_ff @(posedge fastclk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pulse_q  <= '0;
            sw_out_q <= '0;
            bs_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pulse_q  <= pulse_d;
            sw_out_q <= sw_out_d;
            bs_q     <= bs_d;
            busy_q   <= busy_d;
        end
    end

    assign SW            = sw_out_q;
    assign branch_status = bs_q;
    assign busy          = busy_q;

`ifdef PICO_SAMPLE_COUNT_EN
    logic [DATA_W-1:0] count_q, count_d;

    always_comb begin
        if (load_s) count_d = count_q + DATA_W'(1);
        else        count_d = count_q;
    end

    // Accepted-sample counter, wraps naturally.
    always_ff @(posedge fastclk or negedge reset) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end

    assign sample_count = count_q;
`endif

endmodule
